// File: rtl/helios_msg_pkg.sv
// Message codes and FSM state encodings shared by the Helios host-link endpoint.
package helios_msg_pkg;

    localparam logic [7:0] START_DECODING_MSG      = 8'h01;
    localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

    typedef enum logic [2:0] {
        R_IDLE,
        R_WAIT_HDR,
        R_LOAD,
        R_PRESENT,
        R_BUSY
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_ITER,
        T_CYC_HI,
        T_CYC_LO,
        T_CORR
    } tx_state_t;

endpackage

// File: rtl/response_serializer.sv
// Serializes a decoder result to the host: iterations, cycles (MSB first),
// then the core's correction bytes passed straight through.
module response_serializer
    import helios_msg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        result_valid,
    output logic        result_ready,
    input  logic [7:0]  result_iterations,
    input  logic [15:0] result_cycles,
    input  logic [7:0]  corr_data,
    input  logic        corr_valid,
    input  logic        corr_last,
    output logic        corr_ready,
    output logic [7:0]  output_data,
    output logic        output_valid,
    input  logic        output_ready,
    output logic        resp_done
);

    tx_state_t   state;
    logic [7:0]  iter_q;
    logic [15:0] cyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= T_IDLE;
            iter_q    <= '0;
            cyc_q     <= '0;
            resp_done <= 1'b0;
        end else begin
            resp_done <= 1'b0;
            case (state)
                T_IDLE: if (result_valid) begin
                    iter_q <= result_iterations;
                    cyc_q  <= result_cycles;
                    state  <= T_ITER;
                end
                T_ITER:   if (output_ready) state <= T_CYC_HI;
                T_CYC_HI: if (output_ready) state <= T_CYC_LO;
                T_CYC_LO: if (output_ready) state <= T_CORR;
                T_CORR: if (corr_valid && output_ready && corr_last) begin
                    state     <= T_IDLE;
                    resp_done <= 1'b1;
                end
                default: state <= T_IDLE;
            endcase
        end
    end

    // Only T_CORR has a combinational path; header bytes come from latched copies.
    always_comb begin
        result_ready = (state == T_IDLE);
        corr_ready   = 1'b0;
        output_valid = 1'b0;
        output_data  = 8'h00;
        case (state)
            T_ITER:   begin output_valid = 1'b1; output_data = iter_q;       end
            T_CYC_HI: begin output_valid = 1'b1; output_data = cyc_q[15:8];  end
            T_CYC_LO: begin output_valid = 1'b1; output_data = cyc_q[7:0];   end
            T_CORR: begin
                output_valid = corr_valid;
                output_data  = corr_data;
                corr_ready   = output_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/host_link_endpoint.sv
// Host byte-stream endpoint: parses start/header/payload into a measurement
// vector for the decoder core and returns the result through the serializer.
module host_link_endpoint
    import helios_msg_pkg::*;
#(
    parameter int GRID_WIDTH_X = 4,
    parameter int GRID_WIDTH_Z = 2,
    parameter int GRID_WIDTH_U = 3,
    localparam int BYTES_PER_ROUND      = (GRID_WIDTH_X*GRID_WIDTH_Z+7)>>3,
    localparam int ALIGNED_PU_PER_ROUND = BYTES_PER_ROUND*8,
    localparam int TOTAL_BYTES          = BYTES_PER_ROUND*GRID_WIDTH_U,
    localparam int MEAS_W               = ALIGNED_PU_PER_ROUND*GRID_WIDTH_U
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        input_data,
    input  logic              input_valid,
    output logic              input_ready,
    output logic [MEAS_W-1:0] measurements,
    output logic              meas_valid,
    input  logic              meas_ready,
    input  logic              result_valid,
    output logic              result_ready,
    input  logic [7:0]        result_iterations,
    input  logic [15:0]       result_cycles,
    input  logic [7:0]        corr_data,
    input  logic              corr_valid,
    input  logic              corr_last,
    output logic              corr_ready,
    output logic [7:0]        output_data,
    output logic              output_valid,
    input  logic              output_ready,
    output logic              protocol_error
);

    localparam int BCW = $clog2(TOTAL_BYTES+1);

    rx_state_t      rx_state;
    logic [BCW-1:0] byte_cnt;
    logic           resp_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state       <= R_IDLE;
            byte_cnt       <= '0;
            measurements   <= '0;
            protocol_error <= 1'b0;
        end else begin
            case (rx_state)
                R_IDLE: if (input_valid) begin
                    if (input_data == START_DECODING_MSG) rx_state <= R_WAIT_HDR;
                    else                                  protocol_error <= 1'b1;
                end
                R_WAIT_HDR: if (input_valid) begin
                    if (input_data == MEASUREMENT_DATA_HEADER) begin
                        byte_cnt     <= '0;
                        measurements <= '0;
                        rx_state     <= R_LOAD;
                    end else if (input_data != START_DECODING_MSG) begin
                        protocol_error <= 1'b1;
                    end
                end
                // Payload bytes are raw syndrome data, never decoded as headers.
                R_LOAD: if (input_valid) begin
                    for (int k = 0; k < TOTAL_BYTES; k++)
                        if (byte_cnt == BCW'(k)) measurements[8*k +: 8] <= input_data;
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == BCW'(TOTAL_BYTES-1)) rx_state <= R_PRESENT;
                end
                R_PRESENT: if (meas_ready) rx_state <= R_BUSY;
                R_BUSY:    if (resp_done)  rx_state <= R_WAIT_HDR;
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    assign input_ready = (rx_state == R_IDLE) || (rx_state == R_WAIT_HDR) || (rx_state == R_LOAD);
    assign meas_valid  = (rx_state == R_PRESENT);

    response_serializer u_serializer (
        .clk               (clk),
        .reset             (reset),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .result_iterations (result_iterations),
        .result_cycles     (result_cycles),
        .corr_data         (corr_data),
        .corr_valid        (corr_valid),
        .corr_last         (corr_last),
        .corr_ready        (corr_ready),
        .output_data       (output_data),
        .output_valid      (output_valid),
        .output_ready      (output_ready),
        .resp_done         (resp_done)
    );

endmodule
